// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry and
// the 3-bit FSM state encoding.
package imem_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  function automatic logic accepts_bytes(input state_e s);
    return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHECK);
  endfunction

  // The core stays stalled after a failed load so it never runs a partial image.
  function automatic logic holds_cpu(input state_e s);
    return accepts_bytes(s) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles 16-bit words, writes them to the
// instruction RAM at consecutive addresses and verifies an XOR checksum.
//
// state | meaning
// IDLE  | waiting for start, core released
// COUNT | expecting word count N
// HI    | expecting high byte of next word
// LO    | expecting low byte, issues the write
// CHECK | expecting checksum byte
// DONE  | load good, core released
// ERR   | bad count or checksum, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int         IDX_W   = ADDR_W + 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         hi_q, hi_d;
  logic [7:0]         acc_q, acc_d;

  logic               in_ready_q, mem_we_q, cpu_hold_q, load_done_q, load_err_q;
  logic               mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic               take;

  assign take = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    acc_d       = acc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_COUNT;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_COUNT: begin
        if (take) begin
          if ((in_data == 8'd0) || (in_data > DEPTH_B)) begin
            state_d = ST_ERR;
          end else begin
            n_d     = in_data[IDX_W-1:0];
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (take) begin
          hi_d    = in_data;
          acc_d   = acc_q ^ in_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (take) begin
          acc_d       = acc_q ^ in_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ADDR_W-1:0];
          mem_wdata_d = DATA_W'({hi_q, in_data});
          // Index is one bit wider than the address so N == DEPTH ends cleanly.
          idx_d       = idx_q + 1'b1;
          state_d     = (idx_d == n_q) ? ST_CHECK : ST_HI;
        end
      end
      ST_CHECK: begin
        if (take) begin
          state_d = (in_data == acc_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      acc_q       <= acc_d;
      in_ready_q  <= accepts_bytes(state_d);
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= holds_cpu(state_d);
      load_done_q <= (state_d == ST_DONE);
      load_err_q  <= (state_d == ST_ERR);
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level model.
module tb_imem_loader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int we_b2b   = 0;
  logic we_prev = 1'b0;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (mem_we && we_prev) we_b2b++;
    we_prev = mem_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  in_ready,  0);
    check_eq({tag, "_mem_we"},    mem_we,    0);
    check_eq({tag, "_mem_addr"},  mem_addr,  0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_cpu_hold"},  cpu_hold,  0);
    check_eq({tag, "_load_done"}, load_done, 0);
    check_eq({tag, "_load_err"},  load_err,  0);
  endtask

  // Offer one byte, optionally after random bubbles with stray start pulses.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit lo,
                           input logic [ADDR_W-1:0] exp_addr,
                           input logic [DATA_W-1:0] exp_data);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        start    = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    budget   = 0;
    while (!in_ready) begin
      budget++;
      if (budget > 20) begin
        check_eq("handshake_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (lo) begin
      check_eq("wr_we",   mem_we,    1);
      check_eq("wr_addr", mem_addr,  exp_addr);
      check_eq("wr_data", mem_wdata, exp_data);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_ready", in_ready,  1);
    check_eq("start_hold",  cpu_hold,  1);
    check_eq("start_done",  load_done, 0);
    check_eq("start_err",   load_err,  0);
  endtask

  // Model: a frame is good iff 1<=N<=DEPTH and the checksum is the XOR of all data bytes.
  task automatic run_frame(input int n, input logic [15:0] words[$], input bit bad_sum, input bit gaps);
    int   we_base;
    logic [7:0] sum;
    bit   n_ok;
    n_ok = (n >= 1) && (n <= DEPTH);
    pulse_start();
    we_base = we_cnt;
    send_byte(8'(n), gaps, 1'b0, '0, '0);
    if (!n_ok) begin
      check_eq("badn_err",   load_err,  1);
      check_eq("badn_hold",  cpu_hold,  1);
      check_eq("badn_ready", in_ready,  0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("badn_nowrite", we_cnt - we_base, 0);
      return;
    end
    sum = 8'h00;
    for (int k = 0; k < n; k++) begin
      sum ^= words[k][15:8] ^ words[k][7:0];
      send_byte(words[k][15:8], gaps, 1'b0, '0, '0);
      send_byte(words[k][7:0],  gaps, 1'b1, ADDR_W'(k), words[k]);
    end
    if (bad_sum) sum ^= 8'h01;
    send_byte(sum, gaps, 1'b0, '0, '0);
    check_eq("end_done",  load_done, {31'd0, !bad_sum});
    check_eq("end_err",   load_err,  {31'd0, bad_sum});
    check_eq("end_hold",  cpu_hold,  {31'd0, bad_sum});
    check_eq("end_ready", in_ready,  0);
    @(negedge clk);
    check_eq("end_wcount", we_cnt - we_base, n);
  endtask

  initial begin
    logic [15:0] w[$];
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    w = '{16'h1234, 16'hABCD};
    run_frame(2, w, 1'b0, 1'b0);

    // Bytes offered in DONE are not consumed and nothing changes.
    in_data = 8'h55; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_ready", in_ready,  0);
    check_eq("done_stays", load_done, 1);
    in_valid = 1'b0;

    run_frame(2, w, 1'b1, 1'b0);
    run_frame(0, w, 1'b0, 1'b0);
    run_frame(17, w, 1'b0, 1'b0);

    w.delete();
    for (int k = 0; k < 16; k++) w.push_back(16'(k));
    run_frame(16, w, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      w.delete();
      for (int k = 0; k < n; k++) w.push_back(16'($urandom));
      run_frame(n, w, 1'b0, 1'b0);
      run_frame(n, w, ($urandom_range(0, 3) == 0), 1'b1);
    end

    check_eq("we_single_cycle", we_b2b, 0);

    // Reset mid-load after the second data byte of an N=3 load.
    pulse_start();
    send_byte(8'd3,  1'b0, 1'b0, '0, '0);
    send_byte(8'h9A, 1'b0, 1'b0, '0, '0);
    send_byte(8'hBC, 1'b0, 1'b1, 4'd0, 16'h9ABC);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort_rel");
    w = '{16'hC0DE};
    run_frame(1, w, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
